sar_search_driver: RTL and testbench



---
 rtl/sar_search_driver.sv | 176 +++++++++++++++++
 tb/tb_sar_search_driver.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_driver.sv
`default_nettype none
// ============================================================================
// Module      : sar_search_driver
// Description : Binary-search initiator for an external magnitude comparator.
//               Drives the comparator A input with successive midpoint
//               guesses, samples Lt/Gt/Eq one full cycle later, and narrows
//               the [lo, hi] window until the hidden B value is matched, the
//               window empties, or the flags are inconsistent.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_search_driver #(
    parameter int WIDTH = 20,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Lt,
    input  logic             Gt,
    input  logic             Eq,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] compares
);

    // Full search window; lo/hi carry one extra bit so guess+1 never wraps
    localparam logic [WIDTH:0]   C_HI_INIT = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   C_LO_INIT = '0;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH:0]   r_lo;
    logic [WIDTH:0]   r_hi;

    logic [WIDTH:0]   w_guess_ext;
    logic [WIDTH:0]   w_guess_inc;
    logic [WIDTH:0]   w_guess_dec;
    logic [WIDTH-1:0] w_mid;
    logic             w_eq_only;
    logic             w_lt_only;
    logic             w_gt_only;
    logic             w_lt_exhausted;
    logic             w_gt_exhausted;
    logic             w_finish;

    // Window arithmetic: floor midpoint and the candidate new bounds
    assign w_guess_ext    = {1'b0, guess};
    assign w_guess_inc    = w_guess_ext + 1'b1;
    assign w_guess_dec    = w_guess_ext - 1'b1;
    assign w_mid          = WIDTH'(r_lo + ((r_hi - r_lo) >> 1));

    // Exactly one flag must be set; anything else is reported as an error
    assign w_eq_only      =  Eq & ~Lt & ~Gt;
    assign w_lt_only      =  Lt & ~Gt & ~Eq;
    assign w_gt_only      =  Gt & ~Lt & ~Eq;

    // Window becomes empty after moving a bound past the other one
    assign w_lt_exhausted = (w_guess_inc > r_hi);
    assign w_gt_exhausted = (guess == '0) || (w_guess_dec < r_lo);

    // A sample step that leaves the search loop
    assign w_finish       = (r_state == S_SAMPLE) && (w_state_next == S_DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (w_eq_only) begin
                    w_state_next = S_DONE;
                end else if (w_lt_only) begin
                    w_state_next = w_lt_exhausted ? S_DONE : S_DRIVE;
                end else if (w_gt_only) begin
                    w_state_next = w_gt_exhausted ? S_DONE : S_DRIVE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Search datapath: window bounds, guess, status and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo     <= C_LO_INIT;
            r_hi     <= C_HI_INIT;
            guess    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            found    <= 1'b0;
            error    <= 1'b0;
            result   <= '0;
            compares <= '0;
        end else begin
            // done is a single-cycle pulse raised on the final sample step
            done <= w_finish;
            if (w_finish) begin
                busy <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_lo     <= C_LO_INIT;
                        r_hi     <= C_HI_INIT;
                        compares <= '0;
                        found    <= 1'b0;
                        error    <= 1'b0;
                        result   <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    guess <= w_mid;
                end
                S_SAMPLE: begin
                    compares <= compares + C_CNT_ONE;
                    if (w_eq_only) begin
                        found  <= 1'b1;
                        result <= guess;
                    end else if (w_lt_only) begin
                        r_lo <= w_guess_inc;
                    end else if (w_gt_only) begin
                        // guess==0 leaves hi untouched; the search ends anyway
                        if (guess != '0) begin
                            r_hi <= w_guess_dec;
                        end
                    end else begin
                        error <= 1'b1;
                        found <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sar_search_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_search_driver
// Description : Scoreboard bench for sar_search_driver. Stimulus pushes the
//               expected outcome of each search; a monitor pops and compares
//               on every done pulse. Expected outcomes come from a plain
//               integer binary-search model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_search_driver;

    localparam int W = 20;
    localparam int C = 5;

    logic         clk;
    logic         rst;
    logic         start;
    logic         Lt;
    logic         Gt;
    logic         Eq;
    logic [W-1:0] guess;
    logic         busy;
    logic         done;
    logic         found;
    logic         error;
    logic [W-1:0] result;
    logic [C-1:0] compares;

    logic [W-1:0] b_val;
    int           flag_mode;

    typedef struct {
        logic         found;
        logic         error;
        logic [W-1:0] result;
        logic [C-1:0] compares;
        logic [W-1:0] guess;
        int           n;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   passed;
    int   done_seen;
    int   n_launched;
    int   busy_cnt;
    logic prev_done;

    sar_search_driver #(.WIDTH(W), .CNT_W(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Lt       (Lt),
        .Gt       (Gt),
        .Eq       (Eq),
        .guess    (guess),
        .busy     (busy),
        .done     (done),
        .found    (found),
        .error    (error),
        .result   (result),
        .compares (compares)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator: real magnitude compare, or forced invalid flag patterns
    always_comb begin
        Lt = 1'b0;
        Gt = 1'b0;
        Eq = 1'b0;
        case (flag_mode)
            0: begin
                Lt = (guess < b_val);
                Gt = (guess > b_val);
                Eq = (guess == b_val);
            end
            1: begin
                Lt = 1'b1;
                Gt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Reference: textbook binary search over [0, 2^W-1] with integers
    function automatic exp_t model(input logic [W-1:0] b, input int mode);
        exp_t   e;
        longint lo, hi, g, tgt;
        if (mode != 0) begin
            e.found    = 1'b0;
            e.error    = 1'b1;
            e.result   = '0;
            e.compares = C'(1);
            e.guess    = W'((2 ** W - 1) / 2);
            e.n        = 1;
            return e;
        end
        lo  = 0;
        hi  = (64'd1 << W) - 1;
        tgt = longint'(b);
        e.n = 0;
        g   = 0;
        while (1) begin
            g = (lo + hi) / 2;
            e.n++;
            if (g == tgt) break;
            else if (g < tgt) lo = g + 1;
            else hi = g - 1;
        end
        e.found    = 1'b1;
        e.error    = 1'b0;
        e.result   = W'(g);
        e.compares = C'(e.n);
        e.guess    = W'(g);
        return e;
    endfunction

    // Monitor: busy-length tracking and scoreboard compare on every done
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                done_seen++;
                check("done_one_cycle", {31'd0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_done: got done with empty scoreboard expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("found",       {31'd0, found}, {31'd0, e.found});
                    check("error",       {31'd0, error}, {31'd0, e.error});
                    check("result",      32'(result),    32'(e.result));
                    check("compares",    32'(compares),  32'(e.compares));
                    check("final_guess", 32'(guess),     32'(e.guess));
                    check("busy_cycles", 32'(busy_cnt),  32'(2 * e.n));
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                end
                busy_cnt = 0;
            end else if (!busy) begin
                busy_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic launch(input logic [W-1:0] b, input int mode);
        b_val     = b;
        flag_mode = mode;
        exp_q.push_back(model(b, mode));
        n_launched++;
        start = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == budget) begin
            total++;
            $display("FAIL timeout: got no done within %0d cycles expected done", budget);
        end
    endtask

    // Single search with a one-cycle start pulse; returns with DUT in IDLE
    task automatic pulse_search(input logic [W-1:0] b, input int mode);
        launch(b, mode);
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        @(negedge clk);
    endtask

    // Two searches with start held high across the DONE state
    task automatic b2b_search(input logic [W-1:0] b1, input logic [W-1:0] b2);
        launch(b1, 0);
        wait_done(100);
        b_val = b2;
        exp_q.push_back(model(b2, 0));
        n_launched++;
        wait_done(100);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        total      = 0;
        passed     = 0;
        done_seen  = 0;
        n_launched = 0;
        busy_cnt   = 0;
        prev_done  = 1'b0;
        rst        = 1'b1;
        start      = 1'b0;
        b_val      = '0;
        flag_mode  = 0;

        repeat (3) @(negedge clk);
        check("rst_guess",    32'(guess),    32'd0);
        check("rst_busy",     {31'd0, busy}, 32'd0);
        check("rst_done",     {31'd0, done}, 32'd0);
        check("rst_found",    {31'd0, found}, 32'd0);
        check("rst_error",    {31'd0, error}, 32'd0);
        check("rst_result",   32'(result),   32'd0);
        check("rst_compares", 32'(compares), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        pulse_search(20'h7FFFF, 0);
        pulse_search(20'h00000, 0);
        pulse_search(20'hFFFFF, 0);
        b2b_search(20'h00001, 20'h12345);
        pulse_search(20'h00000, 1);
        pulse_search(20'h00000, 2);

        // Asynchronous reset part-way through a search
        launch(20'hABCDE, 0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_guess",    32'(guess),    32'd0);
        check("mid_rst_busy",     {31'd0, busy}, 32'd0);
        check("mid_rst_done",     {31'd0, done}, 32'd0);
        check("mid_rst_found",    {31'd0, found}, 32'd0);
        check("mid_rst_error",    {31'd0, error}, 32'd0);
        check("mid_rst_result",   32'(result),   32'd0);
        check("mid_rst_compares", 32'(compares), 32'd0);
        void'(exp_q.pop_back());
        n_launched--;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_search(20'hABCDE, 0);

        for (int i = 0; i < 8; i++) begin
            pulse_search(W'($urandom), 0);
        end
        b2b_search(W'($urandom), W'($urandom));

        repeat (4) @(negedge clk);
        check("done_pulse_count", 32'(done_seen), 32'(n_launched));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
